// File: rtl/scara_pkg.sv
// Shared types and default timing for the SCARA joint step generators.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package scara_pkg;

    // Pulse sequencer states; the ST_ prefix keeps them clear of timing parameter names.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIR_SETUP = 2'd1,
        ST_PULSE_HI  = 2'd2,
        ST_PULSE_LO  = 2'd3
    } step_state_t;

    // Default timing in clk cycles: 100-cycle pulse, 50000-cycle period, 250-cycle dir setup.
    localparam int DEF_PULSE_HIGH  = 100;
    localparam int DEF_STEP_PERIOD = 50000;
    localparam int DEF_DIR_SETUP   = 250;

    // Bits needed to hold the larger of two cycle counts without wrapping.
    function automatic int phase_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/step_phase_timer.sv
// Loadable down-counter that times each sequencer phase; zero flags phase end.
// Latency: load takes effect on the next edge; zero is combinational from the count flop.
// Backpressure: none; the counter holds at zero until it is reloaded.
module step_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over counting; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dual_stepper_pulser.sv
// Two-joint step pulse generator: one command yields concurrent pulse trains on both joints.
// Latency: outputs update 1 cycle after the dataReady rising edge; first pulse after DIR_SETUP more cycles.
// Backpressure: stepperReady low while busy; commands arriving while busy are dropped, not queued.
module dual_stepper_pulser
    import scara_pkg::*;
#(
    parameter int PULSE_HIGH  = DEF_PULSE_HIGH,
    parameter int STEP_PERIOD = DEF_STEP_PERIOD,
    parameter int DIR_SETUP   = DEF_DIR_SETUP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] steps1,
    input  logic [7:0] steps2,
    input  logic       dir1,
    input  logic       dir2,
    input  logic       dataReady,
    input  logic       halt,
    output logic       stepperReady,
    output logic       step1,
    output logic       step2,
    output logic       dirOut1,
    output logic       dirOut2
);

    localparam int CW = phase_width(STEP_PERIOD, DIR_SETUP);

    // Timer holds length-1 so that a phase lasts exactly its length in cycles.
    localparam logic [CW-1:0] LD_SETUP = CW'(DIR_SETUP - 1);
    localparam logic [CW-1:0] LD_HI    = CW'(PULSE_HIGH - 1);
    localparam logic [CW-1:0] LD_LO    = CW'(STEP_PERIOD - PULSE_HIGH - 1);

    step_state_t   state, state_n;
    logic [7:0]    rem1, rem2, rem1_n, rem2_n;
    logic          step1_n, step2_n, dir1_n, dir2_n;
    logic          dr_prev;
    logic          rise;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_zero;

    step_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // A level held high for many cycles must only start one move.
    assign rise = dataReady & ~dr_prev;

    // Ready is purely a decode of the state flop, so it rises on the cycle IDLE is entered.
    assign stepperReady = (state == ST_IDLE);

    // State, counts and the glitch-free step/direction flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            rem1    <= '0;
            rem2    <= '0;
            step1   <= 1'b0;
            step2   <= 1'b0;
            dirOut1 <= 1'b0;
            dirOut2 <= 1'b0;
            dr_prev <= 1'b0;
        end else begin
            state   <= state_n;
            rem1    <= rem1_n;
            rem2    <= rem2_n;
            step1   <= step1_n;
            step2   <= step2_n;
            dirOut1 <= dir1_n;
            dirOut2 <= dir2_n;
            dr_prev <= dataReady;
        end
    end

    // Next-state and datapath updates; halt overrides everything including a new command.
    always_comb begin
        state_n  = state;
        rem1_n   = rem1;
        rem2_n   = rem2;
        step1_n  = step1;
        step2_n  = step2;
        dir1_n   = dirOut1;
        dir2_n   = dirOut2;
        tmr_load = 1'b0;
        tmr_val  = '0;

        if (halt) begin
            state_n = ST_IDLE;
            rem1_n  = '0;
            rem2_n  = '0;
            step1_n = 1'b0;
            step2_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise && ((steps1 != 8'd0) || (steps2 != 8'd0))) begin
                        state_n  = ST_DIR_SETUP;
                        rem1_n   = steps1;
                        rem2_n   = steps2;
                        dir1_n   = dir1;
                        dir2_n   = dir2;
                        tmr_load = 1'b1;
                        tmr_val  = LD_SETUP;
                    end
                end
                ST_DIR_SETUP: begin
                    if (tmr_zero) begin
                        state_n  = ST_PULSE_HI;
                        step1_n  = (rem1 != 8'd0);
                        step2_n  = (rem2 != 8'd0);
                        tmr_load = 1'b1;
                        tmr_val  = LD_HI;
                    end
                end
                ST_PULSE_HI: begin
                    if (tmr_zero) begin
                        state_n  = ST_PULSE_LO;
                        step1_n  = 1'b0;
                        step2_n  = 1'b0;
                        rem1_n   = (rem1 != 8'd0) ? rem1 - 8'd1 : rem1;
                        rem2_n   = (rem2 != 8'd0) ? rem2 - 8'd1 : rem2;
                        tmr_load = 1'b1;
                        tmr_val  = LD_LO;
                    end
                end
                ST_PULSE_LO: begin
                    if (tmr_zero) begin
                        if ((rem1 == 8'd0) && (rem2 == 8'd0)) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n  = ST_PULSE_HI;
                            step1_n  = (rem1 != 8'd0);
                            step2_n  = (rem2 != 8'd0);
                            tmr_load = 1'b1;
                            tmr_val  = LD_HI;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dual_stepper_pulser.sv
// Directed bench for dual_stepper_pulser with short timing (pulse 2, period 5, setup 3).
// Latency: n/a.
// Backpressure: n/a.
module tb_dual_stepper_pulser;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] steps1, steps2;
    logic       dir1, dir2, dataReady, halt;
    logic       stepperReady, step1, step2, dirOut1, dirOut2;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt1 = 0, cnt2 = 0;
    logic s1p = 1'b0, s2p = 1'b0;

    always #5 clk = ~clk;

    dual_stepper_pulser #(
        .PULSE_HIGH  (2),
        .STEP_PERIOD (5),
        .DIR_SETUP   (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .steps1       (steps1),
        .steps2       (steps2),
        .dir1         (dir1),
        .dir2         (dir2),
        .dataReady    (dataReady),
        .halt         (halt),
        .stepperReady (stepperReady),
        .step1        (step1),
        .step2        (step2),
        .dirOut1      (dirOut1),
        .dirOut2      (dirOut2)
    );

    // Pulse counters sampled on the falling edge, away from output updates.
    always @(negedge clk) begin
        if (step1 && !s1p) cnt1 <= cnt1 + 1;
        if (step2 && !s2p) cnt2 <= cnt2 + 1;
        s1p <= step1;
        s2p <= step2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle command strobe; on return the first post-command edge has been sampled (k=0).
    task automatic strobe(input logic [7:0] a, input logic [7:0] b, input logic da, input logic db);
        steps1    = a;
        steps2    = b;
        dir1      = da;
        dir2      = db;
        dataReady = 1'b1;
        tick();
        dataReady = 1'b0;
    endtask

    initial begin
        logic [31:0] t1, t2, tr, td1, td2;
        int c1, c2, k;

        reset = 1'b1; steps1 = '0; steps2 = '0; dir1 = 0; dir2 = 0; dataReady = 0; halt = 0;
        ticks(3);
        check("rst_ready", 32'(stepperReady), 32'd1);
        check("rst_step",  {30'd0, step1, step2}, 32'd0);
        check("rst_dir",   {30'd0, dirOut1, dirOut2}, 32'd0);
        reset = 1'b0;
        ticks(2);

        // 3/1 move: pulses at k=3,8,13 for joint 1, k=3 for joint 2; ready at k=18.
        t1 = '0; t2 = '0; tr = '0; td1 = '0; td2 = '0;
        strobe(8'd3, 8'd1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            t1[i] = step1; t2[i] = step2; tr[i] = stepperReady;
            td1[i] = dirOut1; td2[i] = dirOut2;
        end
        check("m1_step1_trace", t1, 32'h0000_6318);
        check("m1_step2_trace", t2, 32'h0000_0018);
        check("m1_ready_trace", tr, 32'h000C_0000);
        check("m1_dir1_trace",  td1, 32'h000F_FFFF);
        check("m1_dir2_trace",  td2, 32'h0000_0000);

        // Zero-count command is ignored entirely.
        c1 = cnt1; c2 = cnt2;
        strobe(8'd0, 8'd0, 1'b0, 1'b1);
        check("zero_ready_k0", 32'(stepperReady), 32'd1);
        ticks(8);
        check("zero_ready", 32'(stepperReady), 32'd1);
        check("zero_pulses", 32'((cnt1 - c1) + (cnt2 - c2)), 32'd0);
        check("zero_dir", {30'd0, dirOut1, dirOut2}, 32'h2);

        // 2/2 move: both joints pulse in the same cycles; ready at k=13.
        t1 = '0; t2 = '0; tr = '0;
        strobe(8'd2, 8'd2, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            if (i > 0) tick();
            t1[i] = step1; t2[i] = step2; tr[i] = stepperReady;
        end
        check("m2_step1_trace", t1, 32'h0000_0318);
        check("m2_step2_trace", t2, 32'h0000_0318);
        check("m2_ready_trace", tr, 32'h0000_6000);
        check("m2_dir", {30'd0, dirOut1, dirOut2}, 32'h1);

        // Held dataReady gives one move; a later edge mid-move is dropped, dir untouched.
        c1 = cnt1; c2 = cnt2;
        steps1 = 8'd4; steps2 = 8'd0; dir1 = 1; dir2 = 1; dataReady = 1;
        ticks(10);
        dataReady = 0;
        ticks(2);
        steps1 = 8'd7; dir1 = 0; dir2 = 0; dataReady = 1;
        tick();
        dataReady = 0;
        check("held_busy", 32'(stepperReady), 32'd0);
        ticks(17);
        check("held_ready", 32'(stepperReady), 32'd1);
        check("held_cnt1", 32'(cnt1 - c1), 32'd4);
        check("held_cnt2", 32'(cnt2 - c2), 32'd0);
        check("held_dir", {30'd0, dirOut1, dirOut2}, 32'h3);

        // Halt during a pulse of a 200-step move.
        c1 = cnt1;
        strobe(8'd200, 8'd0, 1'b0, 1'b0);
        k = 0;
        while (!step1 && k < 10) begin tick(); k++; end
        check("halt_seen_pulse", 32'(step1), 32'd1);
        halt = 1;
        tick();
        halt = 0;
        check("halt_step1", 32'(step1), 32'd0);
        check("halt_ready", 32'(stepperReady), 32'd1);
        ticks(20);
        check("halt_no_more", 32'(cnt1 - c1), 32'd1);
        c1 = cnt1; c2 = cnt2;
        strobe(8'd1, 8'd2, 1'b1, 1'b0);
        ticks(15);
        check("post_halt_cnt1", 32'(cnt1 - c1), 32'd1);
        check("post_halt_cnt2", 32'(cnt2 - c2), 32'd2);
        check("post_halt_ready", 32'(stepperReady), 32'd1);

        // Reset during PULSE_LO.
        strobe(8'd5, 8'd5, 1'b1, 1'b1);
        k = 0;
        while (!step1 && k < 10) begin tick(); k++; end
        check("rstmv_seen_pulse", 32'(step1), 32'd1);
        ticks(2);
        reset = 1;
        tick();
        check("rstmv_step", {30'd0, step1, step2}, 32'd0);
        check("rstmv_dir", {30'd0, dirOut1, dirOut2}, 32'd0);
        check("rstmv_ready", 32'(stepperReady), 32'd1);
        reset = 0;
        c1 = cnt1; c2 = cnt2;
        ticks(20);
        check("rstmv_no_more", 32'((cnt1 - c1) + (cnt2 - c2)), 32'd0);

        // Halt coincident with a strobe: command discarded.
        steps1 = 8'd3; steps2 = 8'd0; dir1 = 1; halt = 1; dataReady = 1;
        tick();
        halt = 0; dataReady = 0;
        check("halt_strobe_ready", 32'(stepperReady), 32'd1);
        ticks(15);
        check("halt_strobe_cnt", 32'(cnt1 - c1), 32'd0);
        check("halt_strobe_dir", 32'(dirOut1), 32'd0);

        // dataReady already high as reset releases counts as a new command.
        reset = 1; steps1 = 8'd1; steps2 = 8'd0; dataReady = 1;
        tick();
        reset = 0;
        tick();
        dataReady = 0;
        check("rel_edge_busy", 32'(stepperReady), 32'd0);
        ticks(12);
        check("rel_edge_cnt", 32'(cnt1 - c1), 32'd1);
        check("rel_edge_ready", 32'(stepperReady), 32'd1);

        // Full-scale 255/255 move: ready returns at k = 3 + 5*255.
        c1 = cnt1; c2 = cnt2;
        strobe(8'd255, 8'd255, 1'b0, 1'b0);
        k = 0;
        while (!stepperReady && k < 2000) begin tick(); k++; end
        check("big_ready_at", 32'(k), 32'd1278);
        ticks(10);
        check("big_cnt1", 32'(cnt1 - c1), 32'd255);
        check("big_cnt2", 32'(cnt2 - c2), 32'd255);
        check("big_ready", 32'(stepperReady), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_stepper_pulser.md
DUAL_STEPPER_PULSER -- requirements
Module: dual_stepper_pulser

Interface
REQ-001 Parameter PULSE_HIGH, default 100: step pulse high time, clk cycles, >=1.
REQ-002 Parameter STEP_PERIOD, default 50000: full step period, clk cycles, > PULSE_HIGH.
REQ-003 Parameter DIR_SETUP, default 250: direction setup time before the first pulse, clk cycles, >=1.
REQ-004 clk  input  1  system clock; single clock domain; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 steps1  input  8  step count for joint 1, unsigned.
REQ-007 steps2  input  8  step count for joint 2, unsigned.
REQ-008 dir1  input  1  joint 1 direction.
REQ-009 dir2  input  1  joint 2 direction.
REQ-010 dataReady  input  1  move-command strobe from the controller; level may persist for several cycles.
REQ-011 halt  input  1  abort request.
REQ-012 stepperReady  output  1  high when idle and able to accept a command.
REQ-013 step1, step2  output  1 each  step pulses to the motor drivers.
REQ-014 dirOut1, dirOut2  output  1 each  registered direction lines to the drivers.

Function
REQ-015 The block SHALL act only on the rising edge of dataReady (registered previous value); a held-high level SHALL produce exactly one command.
REQ-016 States: IDLE, DIR_SETUP, PULSE_HI, PULSE_LO.
REQ-017 IDLE with a rising edge at cycle N, and steps1 or steps2 nonzero: at N+1 the block SHALL latch counts into rem1/rem2, drive dirOut1/2 from dir1/2, clear stepperReady, and enter DIR_SETUP.
REQ-018 A rising edge with steps1 == steps2 == 0 SHALL be ignored: stay in IDLE, stepperReady stays 1, no pulses, dirOut unchanged.
REQ-019 DIR_SETUP SHALL last exactly DIR_SETUP cycles, then go to PULSE_HI.
REQ-020 PULSE_HI SHALL last PULSE_HIGH cycles; stepK SHALL be 1 only if remK > 0 at entry. On exit, each nonzero remK SHALL decrement by 1.
REQ-021 PULSE_LO SHALL last STEP_PERIOD - PULSE_HIGH cycles with both step outputs 0. On exit: if rem1 == rem2 == 0, go to IDLE; otherwise go to PULSE_HI.
REQ-022 Both joints SHALL pulse concurrently in the same periods. A move SHALL take max(steps1, steps2) periods. Each joint SHALL emit exactly its own count of pulses.
REQ-023 stepperReady SHALL be 1 exactly when the state is IDLE. It rises on the cycle IDLE is entered.
REQ-024 Rising edges of dataReady outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-025 dirOut1/2 SHALL change only on the latch cycle, never while a move is in progress.
REQ-026 halt in any state SHALL, at the next edge: force step1/2 to 0, clear rem1/rem2, enter IDLE, and raise stepperReady.
REQ-027 halt SHALL take priority over a coincident dataReady rising edge; that command is discarded.
REQ-028 The phase counter SHALL be wide enough for max(STEP_PERIOD, DIR_SETUP) with no wrap-around. rem counters are 8 bits and SHALL never underflow.

Reset
REQ-029 Reset SHALL set: state IDLE, stepperReady 1, step1/step2 0, dirOut1/dirOut2 0, rem1/rem2 0, phase counter 0, and the dataReady history register 0.
REQ-030 Reset asserted mid-move SHALL abort the move with no further pulses. Step outputs SHALL be 0 in the cycle after reset is sampled.
REQ-031 A dataReady level already high when reset releases SHALL count as a rising edge, since the history register is 0.

Structure
REQ-032 The state typedef and the default timing constants SHALL live in a shared package, scara_pkg.
REQ-033 Phase timing SHALL be implemented as one sub-module, step_phase_timer: a loadable down-counter with a load value input, a load strobe and a zero flag. One instance is used.
REQ-034 step1/step2 and dirOut1/dirOut2 SHALL be driven directly from flops (glitch-free).

Verification (benches use PULSE_HIGH=2, STEP_PERIOD=5, DIR_SETUP=3)
REQ-035 steps1=3, steps2=1, dir1=1, dir2=0, one-cycle strobe -> dirOut=1/0 one cycle later; first step pulse 3 cycles after that; step1 gives 3 pulses of 2 cycles each at a 5-cycle period; step2 gives 1 pulse; stepperReady returns high 15 cycles after DIR_SETUP ends.
REQ-036 steps1=0, steps2=0 strobe -> stepperReady stays 1 with no pulses. Then steps1=2, steps2=2 -> both joints give 2 pulses aligned to the same cycles.
REQ-037 dataReady held high for 10 cycles with steps1=4 -> exactly 4 pulses. A second rising edge during the move -> ignored; still 4 pulses total.
REQ-038 halt asserted mid PULSE_HI of a steps1=200 move -> step1 low the next cycle; stepperReady 1; no further pulses; a new strobe is then accepted normally.
REQ-039 Reset asserted during PULSE_LO -> all outputs at reset values the next cycle. halt coincident with a strobe -> no move starts.
REQ-040 steps1=255, steps2=255 -> exactly 255 pulses on each joint; rem never underflows; stepperReady 1 at the end.
